// File: rtl/data_mem_responder.sv
// data_mem_responder: single-port data memory that answers one load/store
// request at a time over a valid/ready request channel and a valid/ready
// response channel. It sign/zero-extends loads, writes only the addressed
// byte lanes on stores, and flags out-of-range, illegal-width and misaligned
// requests.
module data_mem_responder #(
  parameter int                AWIDTH      = 32,
  parameter int                DWIDTH      = 32,
  parameter int                DEPTH_WORDS = 1024,
  parameter logic [AWIDTH-1:0] BASE_ADDR   = 32'h0100_0000,
  parameter int                LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [AWIDTH-1:0] req_addr_i,
  input  logic              req_we_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [DWIDTH-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DWIDTH-1:0] rsp_rdata_o,
  output logic              rsp_err_o
);

  localparam int IDXW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [AWIDTH:0] SPAN = (AWIDTH + 1)'(4 * DEPTH_WORDS);
  // The WAIT countdown starts at LATENCY-2 so that WAIT lasts LATENCY-1 cycles.
  localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [3:0]        cnt;
  logic [3:0]        next_cnt;

  logic [AWIDTH-1:0] addr_q;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [DWIDTH-1:0] wdata_q;
  logic [DWIDTH-1:0] rdata_q;
  logic              err_q;

  logic              accept;
  logic              enter_resp;
  logic              mem_we;

  logic [AWIDTH-1:0] cur_addr;
  logic              cur_we;
  logic [2:0]        cur_f3;
  logic [31:0]       cur_wdata;
  logic [AWIDTH-1:0] offset;
  logic [IDXW-1:0]   word_idx;
  logic [1:0]        lane;

  logic              range_err;
  logic              funct_err;
  logic              align_err;
  logic              req_err;

  logic [31:0]       mem_word;
  logic [31:0]       lane_shifted;
  logic [7:0]        sel_byte;
  logic [15:0]       sel_half;
  logic [31:0]       load_data;
  logic [31:0]       store_data;
  logic [3:0]        store_be;

  // Storage is deliberately left out of reset so it survives a reset pulse.
  logic [31:0]       mem [DEPTH_WORDS];

  assign req_ready_o = (state == IDLE) && rst;
  assign rsp_valid_o = (state == RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

  assign accept     = req_valid_i && req_ready_o;
  assign enter_resp = rst && (state != RESP) && (next_state == RESP);

  // With LATENCY=1 the response is formed on the accept edge itself, so the
  // live request is used; otherwise the latched copy is used.
  assign cur_addr  = (LATENCY == 1) ? req_addr_i   : addr_q;
  assign cur_we    = (LATENCY == 1) ? req_we_i     : we_q;
  assign cur_f3    = (LATENCY == 1) ? req_funct3_i : funct3_q;
  assign cur_wdata = (LATENCY == 1) ? 32'(req_wdata_i) : 32'(wdata_q);

  assign offset   = cur_addr - BASE_ADDR;
  assign word_idx = offset[IDXW+1:2];
  assign lane     = cur_addr[1:0];

  // Fault decode: mapped window, legal width codes and natural alignment.
  always_comb begin
    range_err = (cur_addr < BASE_ADDR) || ({1'b0, offset} >= SPAN);
    funct_err = (cur_f3 == 3'd3) || (cur_f3 == 3'd6) || (cur_f3 == 3'd7) ||
                (cur_we && ((cur_f3 == 3'd4) || (cur_f3 == 3'd5)));
    align_err = (((cur_f3 == 3'd1) || (cur_f3 == 3'd5)) && lane[0]) ||
                ((cur_f3 == 3'd2) && (lane != 2'd0));
    req_err   = range_err || funct_err || align_err;
  end

  // Load path: pick the addressed byte or halfword and extend it.
  always_comb begin
    mem_word     = mem[word_idx];
    lane_shifted = mem_word >> {lane, 3'b000};
    sel_byte     = lane_shifted[7:0];
    sel_half     = lane[1] ? mem_word[31:16] : mem_word[15:0];
    load_data    = 32'd0;
    case (cur_f3)
      3'd0:    load_data = {{24{sel_byte[7]}}, sel_byte};
      3'd4:    load_data = {24'd0, sel_byte};
      3'd1:    load_data = {{16{sel_half[15]}}, sel_half};
      3'd5:    load_data = {16'd0, sel_half};
      3'd2:    load_data = mem_word;
      default: load_data = 32'd0;
    endcase
  end

  // Store path: align the right-justified store data onto its byte lanes.
  always_comb begin
    store_data = cur_wdata << {lane, 3'b000};
    store_be   = 4'b0000;
    case (cur_f3)
      3'd0:    store_be = 4'b0001 << lane;
      3'd1:    store_be = 4'b0011 << lane;
      3'd2:    store_be = 4'b1111;
      default: store_be = 4'b0000;
    endcase
  end

  assign mem_we = enter_resp && cur_we && !req_err;

  // Next-state and WAIT countdown.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            next_state = RESP;
          end else begin
            next_state = WAIT;
            next_cnt   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          next_state = RESP;
        end else begin
          next_cnt = cnt - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
        next_cnt   = 4'd0;
      end
    endcase
  end

  // State, request capture and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      funct3_q <= 3'd0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
      if (accept) begin
        addr_q   <= req_addr_i;
        we_q     <= req_we_i;
        funct3_q <= req_funct3_i;
        wdata_q  <= req_wdata_i;
      end
      if (enter_resp) begin
        rdata_q <= (req_err || cur_we) ? '0 : DWIDTH'(load_data);
        err_q   <= req_err;
      end else if ((state == RESP) && rsp_ready_i) begin
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
    end
  end

  // Byte-lane write into the array on the edge that enters RESP.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (store_be[b]) begin
          mem[word_idx][8*b +: 8] <= store_data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed and randomized checks of data_mem_responder
// against a byte-addressed reference memory kept in the bench.
module tb_data_mem_responder;

  localparam logic [31:0] BASE    = 32'h0100_0000;
  localparam int          DEPTH   = 1024;
  localparam int          LAT     = 2;
  localparam int          TIMEOUT = 20;

  logic        clk;
  logic        rst;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic        req_we_i;
  logic [2:0]  req_funct3_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;

  int test_count;
  int fail_count;

  // Reference memory: one entry per byte that has been stored.
  logic [7:0] ref_mem [int unsigned];

  data_mem_responder #(
    .AWIDTH(32),
    .DWIDTH(32),
    .DEPTH_WORDS(DEPTH),
    .BASE_ADDR(BASE),
    .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i),
    .req_we_i(req_we_i),
    .req_funct3_i(req_funct3_i),
    .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    test_count++;
    assert (observed === expected)
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Reference behaviour of one request; updates ref_mem for legal stores.
  function automatic void modelTxn(input logic we, input logic [2:0] f3,
                                   input logic [31:0] addr, input logic [31:0] wdata,
                                   output logic exp_err, output logic [31:0] exp_rdata,
                                   output bit known);
    int unsigned size;
    logic [31:0] raw;
    exp_err = (addr < BASE) || (addr >= BASE + 4 * DEPTH) ||
              (f3 == 3) || (f3 == 6) || (f3 == 7) ||
              (we && (f3 == 4 || f3 == 5)) ||
              ((f3 == 1 || f3 == 5) && addr[0]) ||
              (f3 == 2 && addr[1:0] != 2'd0);
    exp_rdata = 32'd0;
    known     = 1'b1;
    if (exp_err) return;
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    if (we) begin
      for (int i = 0; i < int'(size); i++) ref_mem[addr + i] = wdata[8*i +: 8];
      return;
    end
    raw = 32'd0;
    for (int i = 0; i < int'(size); i++) begin
      if (ref_mem.exists(addr + i)) raw[8*i +: 8] = ref_mem[addr + i];
      else known = 1'b0;
    end
    case (f3)
      3'd0: exp_rdata = {{24{raw[7]}}, raw[7:0]};
      3'd4: exp_rdata = {24'd0, raw[7:0]};
      3'd1: exp_rdata = {{16{raw[15]}}, raw[15:0]};
      3'd5: exp_rdata = {16'd0, raw[15:0]};
      default: exp_rdata = raw;
    endcase
  endfunction

  // One complete request/response transaction with optional response backpressure.
  task automatic applyStimulus(input logic we, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input int hold, output logic [31:0] obs_rdata,
                               output logic obs_err);
    logic        exp_err;
    logic [31:0] exp_rdata;
    bit          known;
    int          n;
    modelTxn(we, f3, addr, wdata, exp_err, exp_rdata, known);
    @(negedge clk);
    req_valid_i  = 1'b1;
    req_we_i     = we;
    req_funct3_i = f3;
    req_addr_i   = addr;
    req_wdata_i  = wdata;
    n = 0;
    while (req_ready_o !== 1'b1 && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    checkOutput("req_ready_before_accept", 32'(req_ready_o), 32'd1);
    @(posedge clk);
    #1;
    req_valid_i  = 1'b0;
    req_we_i     = 1'($urandom);
    req_funct3_i = 3'($urandom);
    req_addr_i   = $urandom;
    req_wdata_i  = $urandom;
    n = 0;
    while (n < TIMEOUT) begin
      @(negedge clk);
      n++;
      if (rsp_valid_o === 1'b1) break;
    end
    checkOutput("latency", 32'(n), 32'(LAT));
    obs_rdata = rsp_rdata_o;
    obs_err   = rsp_err_o;
    checkOutput("err", 32'(rsp_err_o), 32'(exp_err));
    if (known) checkOutput("rdata", rsp_rdata_o, exp_rdata);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checkOutput("hold_valid", 32'(rsp_valid_o), 32'd1);
      checkOutput("hold_req_ready", 32'(req_ready_o), 32'd0);
      checkOutput("hold_err", 32'(rsp_err_o), 32'(exp_err));
      if (known) checkOutput("hold_rdata", rsp_rdata_o, exp_rdata);
    end
    rsp_ready_i = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready_i = 1'b0;
    checkOutput("idle_after_handshake_valid", 32'(rsp_valid_o), 32'd0);
    checkOutput("idle_after_handshake_ready", 32'(req_ready_o), 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] addr;
    logic [2:0]  f3;
    logic        we;
    test_count   = 0;
    fail_count   = 0;
    rst          = 1'b0;
    req_valid_i  = 1'b0;
    req_we_i     = 1'b0;
    req_funct3_i = 3'd0;
    req_addr_i   = 32'd0;
    req_wdata_i  = 32'd0;
    rsp_ready_i  = 1'b0;

    // Outputs held low while in reset.
    repeat (3) @(negedge clk);
    checkOutput("reset_req_ready", 32'(req_ready_o), 32'd0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
    checkOutput("reset_rdata", rsp_rdata_o, 32'd0);
    checkOutput("reset_err", 32'(rsp_err_o), 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("ready_after_release", 32'(req_ready_o), 32'd1);

    // Word store then reloads of every width.
    applyStimulus(1'b1, 3'd2, BASE + 32'h10, 32'hDEADBEEF, 0, rd, er);
    checkOutput("sw_rdata_zero", rd, 32'd0);
    applyStimulus(1'b0, 3'd2, BASE + 32'h10, 32'd0, 0, rd, er);
    checkOutput("lw_deadbeef", rd, 32'hDEADBEEF);
    applyStimulus(1'b0, 3'd0, BASE + 32'h13, 32'd0, 0, rd, er);
    checkOutput("lb_de", rd, 32'hFFFFFFDE);
    applyStimulus(1'b0, 3'd4, BASE + 32'h13, 32'd0, 0, rd, er);
    checkOutput("lbu_de", rd, 32'h000000DE);
    applyStimulus(1'b0, 3'd1, BASE + 32'h12, 32'd0, 0, rd, er);
    checkOutput("lh_dead", rd, 32'hFFFFDEAD);
    applyStimulus(1'b0, 3'd5, BASE + 32'h10, 32'd0, 0, rd, er);
    checkOutput("lhu_beef", rd, 32'h0000BEEF);

    // Byte store merges into one lane only.
    applyStimulus(1'b1, 3'd0, BASE + 32'h11, 32'h00000055, 0, rd, er);
    applyStimulus(1'b0, 3'd2, BASE + 32'h10, 32'd0, 0, rd, er);
    checkOutput("lw_after_sb", rd, 32'hDEAD55EF);

    // Faulting requests, then confirm the word is untouched.
    applyStimulus(1'b0, 3'd2, BASE + 32'h12, 32'd0, 0, rd, er);
    checkOutput("misaligned_err", 32'(er), 32'd1);
    checkOutput("misaligned_rdata", rd, 32'd0);
    applyStimulus(1'b0, 3'd2, 32'h0000_0000, 32'd0, 0, rd, er);
    checkOutput("unmapped_err", 32'(er), 32'd1);
    applyStimulus(1'b1, 3'd3, BASE + 32'h10, 32'h11111111, 0, rd, er);
    checkOutput("funct3_3_err", 32'(er), 32'd1);
    applyStimulus(1'b1, 3'd2, BASE + 32'h10 - 32'h10 - 32'h4, 32'h22222222, 0, rd, er);
    checkOutput("below_base_err", 32'(er), 32'd1);
    applyStimulus(1'b0, 3'd2, BASE + 32'h10, 32'd0, 0, rd, er);
    checkOutput("reread_unchanged", rd, 32'hDEAD55EF);

    // Response backpressure held for five cycles.
    applyStimulus(1'b0, 3'd2, BASE + 32'h10, 32'd0, 5, rd, er);
    checkOutput("held_rdata", rd, 32'hDEAD55EF);

    // Reset in WAIT abandons the store.
    applyStimulus(1'b1, 3'd2, BASE + 32'h20, 32'hCAFEF00D, 0, rd, er);
    @(negedge clk);
    req_valid_i  = 1'b1;
    req_we_i     = 1'b1;
    req_funct3_i = 3'd2;
    req_addr_i   = BASE + 32'h20;
    req_wdata_i  = 32'h12345678;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    rst         = 1'b0;
    #1;
    checkOutput("wait_reset_valid", 32'(rsp_valid_o), 32'd0);
    checkOutput("wait_reset_ready", 32'(req_ready_o), 32'd0);
    checkOutput("wait_reset_rdata", rsp_rdata_o, 32'd0);
    checkOutput("wait_reset_err", 32'(rsp_err_o), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("ready_after_wait_reset", 32'(req_ready_o), 32'd1);
    applyStimulus(1'b0, 3'd2, BASE + 32'h20, 32'd0, 0, rd, er);
    checkOutput("store_abandoned", rd, 32'hCAFEF00D);

    // Randomized mix near the start and end of the window plus illegal codes.
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 7))
        0:       addr = BASE - 32'($urandom_range(1, 8));
        1:       addr = BASE + 32'(4 * DEPTH) - 32'($urandom_range(0, 7)) + 32'd3;
        default: addr = BASE + 32'($urandom_range(0, 47));
      endcase
      f3 = 3'($urandom_range(0, 7));
      we = 1'($urandom);
      applyStimulus(we, f3, addr, $urandom, $urandom_range(0, 2), rd, er);
    end

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameters SHALL be: AWIDTH, default 32, address width; DWIDTH, default 32, data width; DEPTH_WORDS, default 1024, array size in 32-bit words; BASE_ADDR, default 32'h0100_0000, first mapped byte address; LATENCY, default 2, accept-to-response cycles (legal 1..15).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous assert, active-low (0 = in reset).
REQ-004 req_valid_i  input  1  request present.
REQ-005 req_ready_o  output  1  block can accept a request.
REQ-006 req_addr_i  input  AWIDTH  byte address.
REQ-007 req_we_i  input  1  1 = store, 0 = load.
REQ-008 req_funct3_i  input  3  RV32I width/sign code (0 B, 1 H, 2 W, 4 BU, 5 HU).
REQ-009 req_wdata_i  input  DWIDTH  store data, right-aligned.
REQ-010 rsp_valid_o  output  1  response present.
REQ-011 rsp_ready_i  input  1  consumer takes the response.
REQ-012 rsp_rdata_o  output  DWIDTH  load result, extended to 32 bits; 0 for stores and errors.
REQ-013 rsp_err_o  output  1  request faulted; valid only with rsp_valid_o.

Function
REQ-014 FSM states SHALL be IDLE, WAIT, RESP; req_ready_o = 1 only in IDLE.
REQ-015 Accept when req_valid_i & req_ready_o at edge T; latch addr, we, funct3, wdata; inputs are don't-care afterwards.
REQ-016 rsp_valid_o SHALL first assert in the cycle after edge T+LATENCY-1 (LATENCY=1: RESP entered directly from IDLE; otherwise WAIT holds a down-counter loaded with LATENCY-2 and exits to RESP at 0).
REQ-017 In RESP, rsp_valid_o, rsp_rdata_o and rsp_err_o SHALL hold stable until rsp_valid_o & rsp_ready_i, then return to IDLE; no request is accepted in the handshake cycle.
REQ-018 Error SHALL be flagged when: addr < BASE_ADDR or addr >= BASE_ADDR+4*DEPTH_WORDS; funct3 in {3,6,7}; store with funct3 in {4,5}; H/HU/SH with addr[0]=1; W/SW with addr[1:0]!=0.
REQ-019 Errored requests SHALL NOT modify the array and SHALL return rsp_rdata_o = 0, rsp_err_o = 1.
REQ-020 Word index = (addr - BASE_ADDR) >> 2; byte lanes little-endian, lane = addr[1:0].
REQ-021 Loads: B sign-extends the selected byte, BU zero-extends; H sign-extends the halfword at addr[1], HU zero-extends; W returns the full word.
REQ-022 Stores SHALL write only the addressed lanes (SB: wdata[7:0]; SH: wdata[15:0]; SW: all 4 lanes), committed on the edge entering RESP.
REQ-023 Load data SHALL be sampled from the array on the edge entering RESP, so a store completed earlier is always visible.
REQ-024 Array contents SHALL NOT be cleared by reset; read-before-write contents are undefined.

Reset
REQ-025 While rst = 0: state IDLE, counter 0, req_ready_o 0, rsp_valid_o 0, rsp_rdata_o 0, rsp_err_o 0.
REQ-026 req_ready_o SHALL rise in the first cycle after rst deasserts.
REQ-027 Reset during WAIT SHALL abandon the transaction with no array write; reset during RESP SHALL drop the response.

Verification
REQ-028 LATENCY=2: SW 0xDEADBEEF @0x0100_0010, then LW @0x0100_0010 -> rsp_valid_o 2 cycles after each accept; rdata 0xDEADBEEF, err 0.
REQ-029 After REQ-028 data: LB @0x0100_0013 -> 0xFFFFFFDE; LBU -> 0x000000DE; LH @0x0100_0012 -> 0xFFFFDEAD; LHU @0x0100_0010 -> 0x0000BEEF.
REQ-030 SB 0x55 @0x0100_0011, then LW @0x0100_0010 -> 0xDEAD55EF.
REQ-031 LW @0x0100_0012 (misaligned), LW @0x0000_0000 (unmapped), funct3=3 -> err 1, rdata 0, array unchanged on re-read.
REQ-032 Hold rsp_ready_i=0 for 5 cycles in RESP -> rsp_valid_o/rdata/err stable, req_ready_o 0; rsp_ready_i=1 -> IDLE next cycle.
REQ-033 Accept SW 0x12345678 @0x0100_0020, pull rst low during WAIT -> all outputs 0; after release, LW @0x0100_0020 returns its prior value.
